led_sequencer: RTL and testbench

//  Parametrised successor to the board "basics" LED/key/switch block. Debounces

---
 rtl/led_seq_pkg.sv | 24 ++
 rtl/led_sequencer_if.sv | 16 +
 rtl/led_sequencer_key_debounce.sv | 45 ++++
 rtl/led_sequencer.sv | 171 +++++++++++++++++
 tb/tb_led_sequencer.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequencer: pattern modes, speed index width,
// scan direction and run/pause control states.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_MIRROR = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_SCAN   = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

  localparam int SPEED_W = 2;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/led_sequencer_if.sv
// Board-side pin bundle of the LED sequencer: keys and switches in, LED bank
// and debug status out.
interface led_sequencer_if #(
  parameter int NUM_LEDS = 8,
  parameter int NUM_KEYS = 2,
  parameter int NUM_SW   = 4
);
  logic [NUM_KEYS-1:0] KEY;
  logic [NUM_SW-1:0]   SW;
  logic [NUM_LEDS-1:0] LED;
  logic [1:0]          MODE;
  logic                RUNNING;

  modport master (output KEY, SW, input LED, MODE, RUNNING);
  modport slave  (input KEY, SW, output LED, MODE, RUNNING);
endinterface

// File: rtl/led_sequencer_key_debounce.sv
// One active-low push key: 2-flop synchroniser, stability counter and a
// single-cycle press pulse on the debounced 1->0 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic srst,
  input  logic key_n,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             press_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      press_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        // Level flips; a press is only the released-to-pressed direction.
        level_reg <= sync2_reg;
        press_reg <= level_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign press = press_reg;
endmodule

// File: rtl/led_sequencer.sv
// LED pattern engine: debounced keys drive run/pause, single-step and speed;
// synced switches pick the pattern mode and LED inversion.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_LEDS        = 8,
  parameter int NUM_KEYS        = 2,
  parameter int NUM_SW          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES     = 12500000
) (
  input logic            CLOCK_50,
  input logic            RESET,
  led_sequencer_if.slave bus
);
  localparam int PRESC_W = $clog2(TICK_CYCLES * 8 + 1);
  localparam logic [PRESC_W-1:0] TICK_BASE = PRESC_W'(TICK_CYCLES);

  logic [NUM_KEYS-1:0] key_press;
  logic                unused_keys;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk   (CLOCK_50),
      .srst  (RESET),
      .key_n (bus.KEY[gi]),
      .press (key_press[gi])
    );
  end

  // Keys beyond KEY[1] are debounced but have no function.
  assign unused_keys = ^key_press;

  logic [NUM_SW-1:0] sw_sync1_reg;
  logic [NUM_SW-1:0] sw_sync2_reg;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sw_sync1_reg <= '0;
      sw_sync2_reg <= '0;
    end else begin
      sw_sync1_reg <= bus.SW;
      sw_sync2_reg <= sw_sync1_reg;
    end
  end

  ctrl_state_e          state_reg, state_next;
  logic [SPEED_W-1:0]   speed_reg, speed_next;
  logic [PRESC_W-1:0]   presc_reg, presc_next;
  logic [PRESC_W-1:0]   period;
  logic                 step;

  assign period = TICK_BASE << speed_reg;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_reg <= ST_RUN;
      speed_reg <= '0;
      presc_reg <= '0;
    end else begin
      state_reg <= state_next;
      speed_reg <= speed_next;
      presc_reg <= presc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    speed_next = speed_reg;
    presc_next = presc_reg + PRESC_W'(1);
    step       = 1'b0;
    if (key_press[0]) begin
      state_next = (state_reg == ST_RUN) ? ST_PAUSE : ST_RUN;
    end
    if (state_reg == ST_RUN) begin
      // A speed change beats a coincident tick and restarts the period.
      if (key_press[1]) begin
        speed_next = speed_reg + SPEED_W'(1);
        presc_next = '0;
      end else if (presc_reg == period - PRESC_W'(1)) begin
        presc_next = '0;
        step       = 1'b1;
      end
      if (key_press[0]) begin
        presc_next = '0;
      end
    end else begin
      presc_next = '0;
      step       = key_press[1];
    end
  end

  mode_e               mode_reg;
  mode_e               new_mode;
  logic                mode_change;
  dir_e                dir_reg, dir_next;
  logic [NUM_LEDS-1:0] pattern_reg, pattern_next;
  logic [NUM_LEDS-1:0] sw_pattern;
  logic [NUM_LEDS-1:0] scan_up;
  logic [NUM_LEDS-1:0] scan_down;
  logic [NUM_LEDS-1:0] led_reg;

  assign new_mode    = mode_e'(sw_sync2_reg[1:0]);
  assign mode_change = (new_mode != mode_reg);
  assign sw_pattern  = NUM_LEDS'(sw_sync2_reg);
  assign scan_up     = pattern_reg << 1;
  assign scan_down   = pattern_reg >> 1;

  always_comb begin
    pattern_next = pattern_reg;
    dir_next     = dir_reg;
    if (mode_change) begin
      // Reload for the new mode; any step this cycle is dropped.
      dir_next = DIR_UP;
      case (new_mode)
        MODE_MIRROR: pattern_next = sw_pattern;
        MODE_COUNT:  pattern_next = '0;
        MODE_SCAN:   pattern_next = NUM_LEDS'(1);
        MODE_FILL:   pattern_next = '0;
        default:     pattern_next = '0;
      endcase
    end else begin
      case (mode_reg)
        MODE_MIRROR: pattern_next = sw_pattern;
        MODE_COUNT: begin
          if (step) begin
            pattern_next = sw_sync2_reg[2] ? pattern_reg - NUM_LEDS'(1)
                                           : pattern_reg + NUM_LEDS'(1);
          end
        end
        MODE_SCAN: begin
          if (step && NUM_LEDS > 1) begin
            if (dir_reg == DIR_UP) begin
              pattern_next = scan_up;
              dir_next     = scan_up[NUM_LEDS-1] ? DIR_DOWN : DIR_UP;
            end else begin
              pattern_next = scan_down;
              dir_next     = scan_down[0] ? DIR_UP : DIR_DOWN;
            end
          end
        end
        MODE_FILL: begin
          if (step) begin
            pattern_next = (&pattern_reg) ? '0 : ((pattern_reg << 1) | NUM_LEDS'(1));
          end
        end
        default: pattern_next = pattern_reg;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      mode_reg    <= MODE_MIRROR;
      dir_reg     <= DIR_UP;
      pattern_reg <= '0;
      led_reg     <= '0;
    end else begin
      mode_reg    <= new_mode;
      dir_reg     <= dir_next;
      pattern_reg <= pattern_next;
      led_reg     <= pattern_reg ^ {NUM_LEDS{sw_sync2_reg[3]}};
    end
  end

  assign bus.LED     = led_reg;
  assign bus.MODE    = mode_reg;
  assign bus.RUNNING = (state_reg == ST_RUN);
endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with short debounce/tick periods; every
// expected LED value is hand-derived.
module tb_led_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n;

  always #5 clk = ~clk;

  led_sequencer_if #(.NUM_LEDS(8), .NUM_KEYS(2), .NUM_SW(4)) bus ();

  led_sequencer #(
    .NUM_LEDS(8), .NUM_KEYS(2), .NUM_SW(4),
    .DEBOUNCE_CYCLES(4), .TICK_CYCLES(8)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus)
  );

  logic [7:0] scan_exp [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
  logic [7:0] fill_exp [9]  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("[%0t] %s observed=%0h expected=%0h", $time, tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for the next LED change; n returns the cycles it took.
  task automatic wait_led(input string tag, input int max_cyc, output int cnt);
    logic [7:0] prev;
    prev = bus.LED;
    cnt  = 0;
    do begin
      cycles(1);
      cnt++;
    end while (bus.LED === prev && cnt < max_cyc);
    checks++;
    assert (bus.LED !== prev) else begin
      errors++;
      $error("FAIL %s timeout observed LED=%0h required a change within %0d cycles", tag, bus.LED, max_cyc);
    end
  endtask

  task automatic press_key(input int k);
    bus.KEY[k] = 1'b0;
    cycles(10);
    bus.KEY[k] = 1'b1;
    cycles(10);
  endtask

  initial begin
    // 1: reset state and inverted mirror
    rst = 1'b1;
    bus.KEY = 2'b11;
    bus.SW  = 4'b0000;
    cycles(3);
    check("rst_led", bus.LED, 8'h00);
    check("rst_running", bus.RUNNING, 1'b1);
    check("rst_mode", bus.MODE, 2'd0);
    rst = 1'b0;
    bus.SW = 4'b1000;
    cycles(4);
    // SW itself is mirrored (bit3 set), then the whole bank is inverted.
    check("mirror_inv", bus.LED, 8'hF7);
    check("mirror_mode", bus.MODE, 2'd0);

    // 2: COUNT up, then COUNT down from zero
    bus.SW = 4'b0001;
    cycles(4);
    check("count_reload", bus.LED, 8'h00);
    check("count_mode", bus.MODE, 2'd1);
    wait_led("count1_wait", 40, n);
    check("count1", bus.LED, 8'h01);
    wait_led("count2_wait", 40, n);
    check("count2", bus.LED, 8'h02);
    wait_led("count3_wait", 40, n);
    check("count3", bus.LED, 8'h03);
    check("tick_period_x1", n, 8);
    bus.SW = 4'b0000;
    cycles(4);
    bus.SW = 4'b0101;
    cycles(4);
    check("down_reload", bus.LED, 8'h00);
    wait_led("down_wait", 40, n);
    check("down_wrap", bus.LED, 8'hFF);

    // 3: bouncing KEY[0] gives one toggle; a short glitch gives none
    bus.KEY[0] = 1'b0; cycles(2);
    bus.KEY[0] = 1'b1; cycles(2);
    bus.KEY[0] = 1'b0; cycles(2);
    bus.KEY[0] = 1'b1; cycles(2);
    check("bounce_no_toggle", bus.RUNNING, 1'b1);
    bus.KEY[0] = 1'b0; cycles(10);
    bus.KEY[0] = 1'b1; cycles(10);
    check("bounce_one_toggle", bus.RUNNING, 1'b0);
    bus.KEY[0] = 1'b0; cycles(3);
    bus.KEY[0] = 1'b1; cycles(10);
    check("glitch_ignored", bus.RUNNING, 1'b0);

    // 4: paused single-step in COUNT
    bus.SW = 4'b0000;
    cycles(4);
    bus.SW = 4'b0001;
    cycles(4);
    check("paused_reload", bus.LED, 8'h00);
    for (int i = 0; i < 5; i++) press_key(1);
    check("single_step_5", bus.LED, 8'h05);
    press_key(1);
    check("single_step_6", bus.LED, 8'h06);
    cycles(100);
    check("paused_hold", bus.LED, 8'h06);
    check("paused_running", bus.RUNNING, 1'b0);

    // 5: SCAN bounce, then speed change while running
    press_key(0);
    check("resume", bus.RUNNING, 1'b1);
    bus.SW = 4'b0010;
    cycles(4);
    check("scan_reload", bus.LED, 8'h01);
    check("scan_mode", bus.MODE, 2'd2);
    for (int i = 0; i < 16; i++) begin
      wait_led("scan_wait", 40, n);
      check($sformatf("scan_step%0d", i), bus.LED, scan_exp[i]);
    end
    press_key(1);
    wait_led("speed_wait", 40, n);
    wait_led("speed_wait2", 40, n);
    check("tick_period_x2", n, 16);

    // 6: FILL sequence, then reset mid-sequence
    bus.SW = 4'b0011;
    cycles(4);
    check("fill_reload", bus.LED, 8'h00);
    for (int i = 0; i < 9; i++) begin
      wait_led("fill_wait", 40, n);
      check($sformatf("fill_step%0d", i), bus.LED, fill_exp[i]);
    end
    wait_led("fill_more1", 40, n);
    wait_led("fill_more2", 40, n);
    check("fill_before_rst", bus.LED, 8'h03);
    rst = 1'b1;
    cycles(1);
    check("midrst_led", bus.LED, 8'h00);
    check("midrst_running", bus.RUNNING, 1'b1);
    check("midrst_mode", bus.MODE, 2'd0);
    rst = 1'b0;
    bus.SW = 4'b0000;
    cycles(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
